// File: rtl/pipe_ripple_adder_if.sv
// Stream bundle for pipe_ripple_adder: operand beat in, result beat out.
// The ovf signal exists only when PIPE_ADD_SIGNED_OVF_EN is defined.
interface pipe_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_ADD_SIGNED_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
`endif
endinterface

// File: rtl/pipe_ripple_adder.sv
// Pipelined chunked ripple-carry add/subtract with valid/ready and full-pipe stall.
// Optional signed overflow output: define PIPE_ADD_SIGNED_OVF_EN.
module pipe_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  pipe_ripple_adder_if.slave bus
);
  localparam int CW = WIDTH / ((STAGES < 1) ? 1 : STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_chk
    $error("pipe_ripple_adder: WIDTH must be divisible by STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign b_eff        = bus.b ^ {WIDTH{bus.sub}};
  assign c0           = bus.sub | bus.cin;

  // Stage k holds the settled low (k+1) chunks of the result plus the
  // not-yet-added upper operand chunks, so each chunk meets its carry.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LW = (k + 1) * CW;
    localparam int RW = WIDTH - k * CW;
    localparam int UW = WIDTH - LW;

    logic          v_in;
    logic [RW-1:0] in_a;
    logic [RW-1:0] in_b;
    logic          c_in;
    logic [CW-1:0] op_a;
    logic [CW-1:0] op_b;
    logic [CW-1:0] ch_sum;
    logic          c_rip;
    logic          c_out;
    logic [LW-1:0] s_d;
    logic          load;
    logic          v_q;
    logic          c_q;
    logic [LW-1:0] s_q;

    if (k == 0) begin : g_head
      assign v_in = bus.in_valid;
      assign in_a = bus.a;
      assign in_b = b_eff;
      assign c_in = c0;
      assign s_d  = ch_sum;
    end else begin : g_body
      assign v_in = g_stg[k-1].v_q;
      assign in_a = g_stg[k-1].g_fwd.a_q;
      assign in_b = g_stg[k-1].g_fwd.b_q;
      assign c_in = g_stg[k-1].c_q;
      assign s_d  = {ch_sum, g_stg[k-1].s_q};
    end

    assign op_a = in_a[CW-1:0];
    assign op_b = in_b[CW-1:0];
    // Data registers load only on real beats so outputs stay put across bubbles.
    assign load = ~stall & v_in;

    always_comb begin
      c_rip  = c_in;
      ch_sum = '0;
      for (int i = 0; i < CW; i++) begin
        ch_sum[i] = op_a[i] ^ op_b[i] ^ c_rip;
        c_rip     = (op_a[i] & op_b[i]) | (c_rip & (op_a[i] ^ op_b[i]));
      end
      c_out = c_rip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q <= v_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q <= 1'b0;
        s_q <= '0;
      end else if (load) begin
        c_q <= c_out;
        s_q <= s_d;
      end
    end

    if (UW > 0) begin : g_fwd
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= in_a[RW-1:CW];
          b_q <= in_b[RW-1:CW];
        end
      end
    end
  end

  assign bus.out_valid = g_stg[STAGES-1].v_q;
  assign bus.sum       = g_stg[STAGES-1].s_q;
  assign bus.cout      = g_stg[STAGES-1].c_q;

`ifdef PIPE_ADD_SIGNED_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB recovered from the MSB sum bit: a ^ b ^ s.
  assign ovf_d = g_stg[STAGES-1].c_out ^
                 (g_stg[STAGES-1].op_a[CW-1] ^ g_stg[STAGES-1].op_b[CW-1] ^
                  g_stg[STAGES-1].ch_sum[CW-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (g_stg[STAGES-1].load) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Directed bench for pipe_ripple_adder: main 16/4 instance plus 16/1 and 16/16 latency checks.
module tb_pipe_ripple_adder;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pipe_ripple_adder_if #(.WIDTH(16)) bus4  ();
  pipe_ripple_adder_if #(.WIDTH(16)) bus1  ();
  pipe_ripple_adder_if #(.WIDTH(16)) bus16 ();

  pipe_ripple_adder #(.WIDTH(16), .STAGES(4))  u_dut (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pipe_ripple_adder #(.WIDTH(16), .STAGES(1))  u_s1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_ripple_adder #(.WIDTH(16), .STAGES(16)) u_s16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    bus4.in_valid = 1'b1;
    bus4.a        = a;
    bus4.b        = b;
    bus4.cin      = cin;
    bus4.sub      = sub;
  endtask

  task automatic idle();
    bus4.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus16.in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] s, input logic c);
    chk({tag, ".valid"}, 32'(bus4.out_valid), 32'd1);
    chk({tag, ".sum"},   32'(bus4.sum),       32'(s));
    chk({tag, ".cout"},  32'(bus4.cout),      32'(c));
  endtask

  int          lat1, lat4, lat16, stale;
  logic [15:0] sum1, sum4, sum16;
  logic        co1, co4, co16;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus4.in_valid = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.cin = 1'b0;  bus4.sub = 1'b0;  bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0;  bus1.a = '0;  bus1.b = '0;  bus1.cin = 1'b0;  bus1.sub = 1'b0;  bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
    tick();
    tick();
    chk("rst.valid", 32'(bus4.out_valid), 32'd0);
    chk("rst.sum",   32'(bus4.sum),       32'd0);
    chk("rst.cout",  32'(bus4.cout),      32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(bus4.in_ready), 32'd1);
    tick();

    // Carry crossing every stage, latency on all three depths
    bus4.a = 16'hFFFF;  bus4.b = 16'h0001;  bus4.cin = 1'b0;  bus4.sub = 1'b0;  bus4.in_valid = 1'b1;
    bus1.a = 16'hFFFF;  bus1.b = 16'h0001;  bus1.cin = 1'b0;  bus1.sub = 1'b0;  bus1.in_valid = 1'b1;
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.in_valid = 1'b1;
    lat1 = 0; lat4 = 0; lat16 = 0;
    sum1 = 'x; sum4 = 'x; sum16 = 'x; co1 = 1'bx; co4 = 1'bx; co16 = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) idle();
      if (lat1 == 0 && bus1.out_valid) begin lat1 = n; sum1 = bus1.sum; co1 = bus1.cout; end
      if (lat4 == 0 && bus4.out_valid) begin lat4 = n; sum4 = bus4.sum; co4 = bus4.cout; end
      if (lat16 == 0 && bus16.out_valid) begin lat16 = n; sum16 = bus16.sum; co16 = bus16.cout; end
    end
    chk("s4.latency",  32'(lat4),  32'd4);
    chk("s4.sum",      32'(sum4),  32'h0000);
    chk("s4.cout",     32'(co4),   32'd1);
    chk("s1.latency",  32'(lat1),  32'd1);
    chk("s1.sum",      32'(sum1),  32'h0000);
    chk("s1.cout",     32'(co1),   32'd1);
    chk("s16.latency", 32'(lat16), 32'd16);
    chk("s16.sum",     32'(sum16), 32'h0000);
    chk("s16.cout",    32'(co16),  32'd1);
    chk("idle.sum_stable", 32'(bus4.sum), 32'h0000);

    // Back-to-back beats
    put(16'h1234, 16'h1111, 1'b0, 1'b0); tick();
    put(16'h00FF, 16'h0001, 1'b1, 1'b0); tick();
    put(16'h8000, 16'h8000, 1'b0, 1'b0); tick();
    idle();
    chk("b2b.not_yet", 32'(bus4.out_valid), 32'd0);
    tick(); chk_out("b2b0", 16'h2345, 1'b0);
    tick(); chk_out("b2b1", 16'h0101, 1'b0);
    tick(); chk_out("b2b2", 16'h0000, 1'b1);
    tick(); chk("b2b.drain", 32'(bus4.out_valid), 32'd0);

    // Backpressure with a new beat waiting at the input
    put(16'h0001, 16'h0002, 1'b0, 1'b0); tick();
    put(16'h0010, 16'h0001, 1'b0, 1'b0); tick();
    put(16'h0020, 16'h0002, 1'b0, 1'b0); tick();
    put(16'h0030, 16'h0003, 1'b0, 1'b0); tick();
    chk_out("bp.head", 16'h0003, 1'b0);
    bus4.out_ready = 1'b0;
    put(16'h1000, 16'h2000, 1'b0, 1'b0);
    #1;
    chk("bp.in_ready_low", 32'(bus4.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.hold", 16'h0003, 1'b0);
      chk("bp.hold.in_ready", 32'(bus4.in_ready), 32'd0);
    end
    bus4.out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", 32'(bus4.in_ready), 32'd1);
    tick(); idle();
    chk_out("bp.r0", 16'h0011, 1'b0);
    tick(); chk_out("bp.r1", 16'h0022, 1'b0);
    tick(); chk_out("bp.r2", 16'h0033, 1'b0);
    tick(); chk_out("bp.r3", 16'h3000, 1'b0);
    tick(); chk("bp.drain", 32'(bus4.out_valid), 32'd0);

    // Subtract; cin must be ignored
    put(16'h0005, 16'h0007, 1'b1, 1'b1); tick();
    put(16'h0007, 16'h0005, 1'b1, 1'b1); tick();
    idle();
    tick(); tick();
    chk_out("sub0", 16'hFFFE, 1'b0);
    tick(); chk_out("sub1", 16'h0002, 1'b1);
    tick();

    // Signed overflow corners
    put(16'h7FFF, 16'h0001, 1'b0, 1'b0); tick();
    put(16'h8000, 16'h0001, 1'b0, 1'b1); tick();
    put(16'hFFFF, 16'h0001, 1'b0, 1'b0); tick();
    idle();
    tick();
    chk_out("ovf0", 16'h8000, 1'b0);
`ifdef PIPE_ADD_SIGNED_OVF_EN
    chk("ovf0.ovf", 32'(bus4.ovf), 32'd1);
`endif
    tick(); chk_out("ovf1", 16'h7FFF, 1'b1);
`ifdef PIPE_ADD_SIGNED_OVF_EN
    chk("ovf1.ovf", 32'(bus4.ovf), 32'd1);
`endif
    tick(); chk_out("ovf2", 16'h0000, 1'b1);
`ifdef PIPE_ADD_SIGNED_OVF_EN
    chk("ovf2.ovf", 32'(bus4.ovf), 32'd0);
`endif
    tick();

    // Asynchronous reset with one beat at the output and three in flight
    put(16'hF000, 16'h2000, 1'b0, 1'b0); tick();
    put(16'h0001, 16'h0001, 1'b0, 1'b0); tick();
    put(16'h0002, 16'h0002, 1'b0, 1'b0); tick();
    put(16'h0003, 16'h0003, 1'b0, 1'b0); tick();
    idle();
    chk_out("mid.pre", 16'h1000, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.valid", 32'(bus4.out_valid), 32'd0);
    chk("mid.sum",   32'(bus4.sum),       32'd0);
    chk("mid.cout",  32'(bus4.cout),      32'd0);
`ifdef PIPE_ADD_SIGNED_OVF_EN
    chk("mid.ovf",   32'(bus4.ovf),       32'd0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("mid.in_ready", 32'(bus4.in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus4.out_valid) stale++;
    end
    chk("mid.no_stale", 32'(stale), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
